game_controller: RTL and testbench
==================================

# game_controller

Round-level game FSM for the whack-a-mole design; sits directly downstream of the mole detector. It consumes the detector's `hit_pulse`/`miss_pulse` and the 1 ms `tick`, and owns game start, lives, the countdown clock and level progression. It feeds `interval_ms` back to the LED timer and gates LED activation with `playing`.

## Interface
Parameters:
- `START_LIVES`, default 3: lives loaded at game start (1..MAX_LIVES).
- `MAX_LIVES`, default 5: lives ceiling (≤7).
- `GAME_S`, default 60: round length in seconds (1..99).
- `HITS_PER_LEVEL`, default 5: hits needed per level-up (≥1).
- `N_LEVELS`, default 8: number of levels, 0..N_LEVELS-1 (≤8).
- `BASE_INTERVAL_MS`, default 1000: mole interval at level 0.
- `STEP_MS`, default 100: interval decrement per level. Requires BASE_INTERVAL_MS − (N_LEVELS−1)·STEP_MS ≥ 1.
- `STREAK_LEN`, default 5: consecutive hits needed to earn a bonus life (STREAK_BONUS_EN only).

Ports:
- `clk`, in, 1: system clock (CLOCK_50 domain).
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: 1-cycle pulse every 1 ms.
- `start_pulse`, in, 1: 1-cycle debounced start request.
- `hit_pulse`, in, 1: 1-cycle hit from the mole detector.
- `miss_pulse`, in, 1: 1-cycle miss from the mole detector.
- `playing`, out, 1: high while state is PLAY.
- `game_over`, out, 1: high while state is OVER.
- `lives`, out, 3: remaining lives.
- `level`, out, 3: current level.
- `time_left_s`, out, 7: whole seconds remaining.
- `interval_ms`, out, 10: mole interval for the timer. Equals BASE_INTERVAL_MS − level·STEP_MS.

## Operation
- States: IDLE, PLAY, OVER.
- **IDLE → PLAY** on `start_pulse`.
  - Load lives=START_LIVES, level=0, hit_cnt=0, streak=0.
  - Load time_left_s=GAME_S, ms_cnt=999.
- **OVER → PLAY** on `start_pulse`, with the same loads. No other exit from OVER.
- **PLAY, tick:**
  - If ms_cnt>0: ms_cnt−1.
  - Otherwise: ms_cnt=999, time_left_s−1.
  - If time_left_s reaches 0 → OVER.
- **PLAY, hit:**
  - hit_cnt+1.
  - At HITS_PER_LEVEL: hit_cnt=0 and level+1, saturating at N_LEVELS−1. At saturation, hit_cnt still wraps.
- **PLAY, miss:**
  - lives−1.
  - If lives was 1: lives=0 → OVER.
- Arithmetic:
  - Counters saturate and never wrap below 0.
  - interval_ms is computed combinationally from the level register, with no extra latency.
- Ignored inputs:
  - `start_pulse` during PLAY is ignored.
  - hit, miss and tick are ignored in IDLE and OVER. Counters hold.
- Simultaneous events in one cycle (PLAY): all are applied independently, with these precedence rules:
  - Any OVER condition (last life lost, or time reaching 0) wins. Level and hit_cnt updates from that cycle are discarded.
  - lives and time_left_s still show their final values.
  - hit+miss, neither fatal: both take effect (hit_cnt/level advance, lives−1).
- OVER holds lives, level and time_left_s frozen for display.

## Timing
- All outputs are registered, except interval_ms (combinational from the level register).
- Reset values:
  - state=IDLE, playing=0, game_over=0.
  - lives=0, level=0, time_left_s=0.
  - interval_ms=BASE_INTERVAL_MS.
- Latency: an input pulse at edge N is reflected in outputs after edge N+1.
- `playing` rises 1 cycle after `start_pulse`.
- Round duration: exactly GAME_S·1000 ticks from entering PLAY to OVER, with no misses.
- Reset mid-PLAY: on the next edge, all state returns to reset values. Pulses coincident with `rst` are dropped.

## Configuration
- Macro: `GAME_CONTROLLER_STREAK_BONUS_EN`.
- When defined:
  - A streak counter counts consecutive hits. A miss clears it.
  - When it reaches STREAK_LEN: lives+1 (saturating at MAX_LIVES) and streak clears.
  - A hit+miss in the same cycle clears the streak and awards no bonus.
- When undefined: no streak logic is built, and lives only decrement.

## Test plan
- **Reset then start:** `rst` high 2 cycles, then `start_pulse` → next cycle playing=1, lives=3, level=0, time_left_s=60, interval_ms=1000.
- **Level-up:** 5 hits → level=1, interval_ms=900. 35 more hits → level=7, interval_ms=300. 5 more hits → level stays 7.
- **Lives to zero:** 3 misses → lives=0, game_over=1, playing=0. Further hits leave level unchanged.
- **Timeout:** 60000 ticks with no events → time_left_s steps 60→0 once per 1000 ticks, then game_over=1. A later `start_pulse` restarts with time_left_s=60.
- **Simultaneous events:** lives=1 with hit+miss on the same cycle → OVER, hit_cnt/level unchanged. lives=2 with hit+miss → lives=1, hit counted.
- **Streak (macro defined):** lives=3 and 5 consecutive hits → lives=4. At lives=5, 5 more hits → lives stays 5. Hit×4, then miss, then hit×4 → no bonus.

Source files
------------

// File: rtl/game_controller.sv
// game_controller: round FSM owning start, lives, countdown and level progression.
// Optional streak bonus life enabled by defining GAME_CONTROLLER_STREAK_BONUS_EN.
module game_controller #(
   parameter int START_LIVES      = 3,
   parameter int MAX_LIVES        = 5,
   parameter int GAME_S           = 60,
   parameter int HITS_PER_LEVEL   = 5,
   parameter int N_LEVELS         = 8,
   parameter int BASE_INTERVAL_MS = 1000,
   parameter int STEP_MS          = 100,
   parameter int STREAK_LEN       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_pulse,
   input  logic       hit_pulse,
   input  logic       miss_pulse,
   output logic       playing,
   output logic       game_over,
   output logic [2:0] lives,
   output logic [2:0] level,
   output logic [6:0] time_left_s,
   output logic [9:0] interval_ms
);
   localparam int HW = $clog2(HITS_PER_LEVEL + 1);
   localparam logic [HW-1:0] HPL = HW'(HITS_PER_LEVEL);
   localparam logic [2:0] LSTART = 3'(START_LIVES > MAX_LIVES ? MAX_LIVES : START_LIVES);
   localparam logic [2:0] LTOP = 3'(N_LEVELS - 1);
   localparam logic [6:0] GS = 7'(GAME_S);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t state, state_n;
   logic [2:0] lives_n, level_n;
   logic [6:0] time_n;
   logic [9:0] ms_cnt, ms_n;
   logic [HW-1:0] hit_cnt, hit_n, hit_inc;
   logic fatal_miss;
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
   localparam int SW = $clog2(STREAK_LEN + 1);
   localparam logic [SW-1:0] SL = SW'(STREAK_LEN);
   localparam logic [2:0] LMAX = 3'(MAX_LIVES);
   logic [SW-1:0] streak, streak_n, streak_inc;
`endif

   assign playing     = (state == PLAY);
   assign game_over   = (state == OVER);
   assign interval_ms = 10'(BASE_INTERVAL_MS - STEP_MS * int'(level));

   // state and round counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lives       <= '0;
         level       <= '0;
         time_left_s <= '0;
         ms_cnt      <= '0;
         hit_cnt     <= '0;
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
         streak      <= '0;
`endif
      end else begin
         state       <= state_n;
         lives       <= lives_n;
         level       <= level_n;
         time_left_s <= time_n;
         ms_cnt      <= ms_n;
         hit_cnt     <= hit_n;
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
         streak      <= streak_n;
`endif
      end
   end

   // next state: start loads, in-play events applied independently, fatal events win over level progress
   always_comb begin
      state_n    = state;
      lives_n    = lives;
      level_n    = level;
      time_n     = time_left_s;
      ms_n       = ms_cnt;
      hit_n      = hit_cnt;
      hit_inc    = hit_cnt + 1'b1;
      fatal_miss = 1'b0;
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
      streak_n   = streak;
      streak_inc = streak + 1'b1;
`endif
      if (state != PLAY) begin
         if (start_pulse) begin
            state_n = PLAY;
            lives_n = LSTART;
            level_n = '0;
            time_n  = GS;
            ms_n    = 10'd999;
            hit_n   = '0;
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
            streak_n = '0;
`endif
         end
      end else begin
         if (tick) begin
            ms_n = (ms_cnt != '0) ? ms_cnt - 1'b1 : 10'd999;
            if (ms_cnt == '0 && time_left_s != '0)
               time_n = time_left_s - 1'b1;
         end
         if (hit_pulse) begin
            hit_n = (hit_inc == HPL) ? '0 : hit_inc;
            if (hit_inc == HPL && level != LTOP)
               level_n = level + 1'b1;
         end
         if (miss_pulse) begin
            lives_n    = (lives != '0) ? lives - 1'b1 : '0;
            fatal_miss = (lives == 3'd1);
         end
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
         if (miss_pulse)
            streak_n = '0;
         else if (hit_pulse) begin
            streak_n = (streak_inc == SL) ? '0 : streak_inc;
            if (streak_inc == SL && lives != LMAX)
               lives_n = lives + 1'b1;
         end
`endif
         if (fatal_miss || time_n == '0) begin
            state_n = OVER;
            level_n = level;
            hit_n   = hit_cnt;
         end
      end
   end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed test-plan sequences plus random traffic against a round-level model.
module tb_game_controller;
   localparam int START_LIVES = 3, MAX_LIVES = 5, GAME_S = 60, HPL = 5;
   localparam int N_LEVELS = 8, BASE = 1000, STEP = 100, STREAK_LEN = 5;

   logic clk = 0, rst = 0, tick = 0, start_pulse = 0, hit_pulse = 0, miss_pulse = 0;
   logic playing, game_over;
   logic [2:0] lives, level;
   logic [6:0] time_left_s;
   logic [9:0] interval_ms;

   int vectors = 0, errors = 0;
   // round model: time derives from elapsed ticks, level from accepted hits
   bit m_play = 0, m_over = 0, m_started = 0;
   int m_lives = 0, m_elapsed = 0, m_hits = 0, m_streak = 0;

   game_controller dut (
      .clk(clk), .rst(rst), .tick(tick), .start_pulse(start_pulse),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .playing(playing),
      .game_over(game_over), .lives(lives), .level(level),
      .time_left_s(time_left_s), .interval_ms(interval_ms)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_level();
      return (m_hits / HPL > N_LEVELS - 1) ? N_LEVELS - 1 : m_hits / HPL;
   endfunction

   function automatic int m_time();
      return m_started ? GAME_S - m_elapsed / 1000 : 0;
   endfunction

   task automatic model(input bit r, input bit s, input bit t, input bit h, input bit m);
      int nl, ne;
      if (r) begin
         m_play = 0; m_over = 0; m_started = 0;
         m_lives = 0; m_elapsed = 0; m_hits = 0; m_streak = 0;
      end else if (!m_play) begin
         if (s) begin
            m_play = 1; m_over = 0; m_started = 1;
            m_lives = START_LIVES; m_elapsed = 0; m_hits = 0; m_streak = 0;
         end
      end else begin
         nl = m_lives - int'(m);
         ne = m_elapsed + int'(t);
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
         if (m) m_streak = 0;
         else if (h) begin
            m_streak++;
            if (m_streak == STREAK_LEN) begin
               m_streak = 0;
               if (nl < MAX_LIVES) nl++;
            end
         end
`endif
         if (nl == 0 || ne == GAME_S * 1000) begin
            m_play = 0; m_over = 1;
         end else m_hits += int'(h);
         m_lives = nl; m_elapsed = ne;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit t, input bit h, input bit m);
      rst = r; start_pulse = s; tick = t; hit_pulse = h; miss_pulse = m;
      @(posedge clk);
      model(r, s, t, h, m);
      #1;
      check("playing", playing, m_play);
      check("game_over", game_over, m_over);
      check("lives", lives, m_lives);
      check("level", level, m_level());
      check("time_left_s", time_left_s, m_time());
      check("interval_ms", interval_ms, BASE - STEP * m_level());
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("reset_interval", interval_ms, 1000);
      check("reset_time", time_left_s, 0);
      step(0, 1, 0, 0, 0);
      check("start_playing", playing, 1);
      check("start_lives", lives, 3);
      check("start_time", time_left_s, 60);
      check("start_interval", interval_ms, 1000);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      check("lvl1", level, 1);
      check("lvl1_interval", interval_ms, 900);
      for (int i = 0; i < 35; i++) step(0, 0, 0, 1, 0);
      check("lvl7", level, 7);
      check("lvl7_interval", interval_ms, 300);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      check("lvl_sat", level, 7);
`ifndef GAME_CONTROLLER_STREAK_BONUS_EN
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      check("dead_lives", lives, 0);
      check("dead_over", game_over, 1);
      check("dead_playing", playing, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);
      check("over_level_frozen", level, 7);
`endif
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 60000; i++) step(0, 0, 1, 0, 0);
      check("timeout_over", game_over, 1);
      check("timeout_time", time_left_s, 0);
      step(0, 1, 0, 0, 0);
      check("restart_time", time_left_s, 60);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      check("fatal_hit_over", game_over, 1);
      check("fatal_hit_level", level, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      check("hitmiss_lives", lives, 1);
      check("hitmiss_level", level, 1);
      step(1, 0, 1, 1, 1);
      check("midplay_reset", playing, 0);
`ifdef GAME_CONTROLLER_STREAK_BONUS_EN
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      check("streak_bonus", lives, 4);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
      check("streak_sat", lives, 5);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      check("streak_broken", lives, 4);
`endif
      for (int i = 0; i < 6000; i++)
         step($urandom_range(499) == 0, $urandom_range(39) == 0, $urandom_range(1) == 0,
              $urandom_range(2) == 0, $urandom_range(11) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
